// File: rtl/uc_pkg.sv
// Shared types and encodings for the control unit, datapath and ALU bench.
// With UC_ILLEGAL_TRAP_EN defined, the state type gains TRAP and widens to 3 bits.
package uc_pkg;

`ifdef UC_ILLEGAL_TRAP_EN
   typedef enum logic [2:0] {T0, T1, T2, T3, TRAP} state_t;
`else
   typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
`endif

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_NAND = 3'b100;

   localparam logic [2:0] ULA_ADD  = 3'b000;
   localparam logic [2:0] ULA_SUB  = 3'b001;
   localparam logic [2:0] ULA_NAND = 3'b010;
   localparam logic [2:0] ULA_PASS = 3'b111;

endpackage

// File: rtl/unidade_controle_dec_onehot.sv
// 3-bit register index to NREG-bit one-hot; indices >= NREG give all zeros.
module dec_onehot #(
   parameter int NREG = 8
) (
   input  logic [2:0]      i_idx,
   output logic [NREG-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      for (int i = 0; i < NREG; i++)
         o_onehot[i] = (i_idx == 3'(i));
   end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control FSM (T0..T3) sequencing the register file, A/G latches and ALU.
// Macro UC_ILLEGAL_TRAP_EN adds the Erro port and a sticky TRAP state for undefined opcodes.
module unidade_controle
   import uc_pkg::*;
#(
   parameter int NREG = 8,
   parameter int IW   = 9
) (
   input  logic            Clock,
   input  logic            Resetn,
   input  logic            Run,
   input  logic [IW-1:0]   DIN,
   output logic            IRin,
   output logic [NREG-1:0] Rin,
   output logic [NREG-1:0] Rout,
   output logic            Ain,
   output logic            Gin,
   output logic            Gout,
   output logic            DINout,
   output logic [2:0]      OpSelect,
   output logic            Done
`ifdef UC_ILLEGAL_TRAP_EN
   ,
   output logic            Erro
`endif
);

   state_t          r_state, w_next;
   logic [IW-1:0]   r_ir;
   logic [2:0]      w_op;
   logic [NREG-1:0] w_x, w_y;

   assign w_op = r_ir[IW-1 -: 3];

   dec_onehot #(.NREG(NREG)) u_dec_x (.i_idx(r_ir[5:3]), .o_onehot(w_x));
   dec_onehot #(.NREG(NREG)) u_dec_y (.i_idx(r_ir[2:0]), .o_onehot(w_y));

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state <= T0;
         r_ir    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == T0 && Run)
            r_ir <= DIN;
      end
   end

   always_comb begin
      w_next   = r_state;
      IRin     = 1'b0;
      Rin      = '0;
      Rout     = '0;
      Ain      = 1'b0;
      Gin      = 1'b0;
      Gout     = 1'b0;
      DINout   = 1'b0;
      OpSelect = ULA_PASS;
      Done     = 1'b0;
`ifdef UC_ILLEGAL_TRAP_EN
      Erro     = 1'b0;
`endif
      case (r_state)
         T0: begin
            IRin = Run;
            if (Run)
               w_next = T1;
         end
         T1: begin
            case (w_op)
               OP_MV: begin
                  Rout   = w_y;
                  Rin    = w_x;
                  Done   = 1'b1;
                  w_next = T0;
               end
               OP_MVI: begin
                  DINout = 1'b1;
                  Rin    = w_x;
                  Done   = 1'b1;
                  w_next = T0;
               end
               OP_ADD, OP_SUB, OP_NAND: begin
                  Rout   = w_x;
                  Ain    = 1'b1;
                  w_next = T2;
               end
               default: begin
`ifdef UC_ILLEGAL_TRAP_EN
                  w_next = TRAP;
`else
                  Done   = 1'b1;
                  w_next = T0;
`endif
               end
            endcase
         end
         T2: begin
            Rout   = w_y;
            Gin    = 1'b1;
            w_next = T3;
            case (w_op)
               OP_ADD:  OpSelect = ULA_ADD;
               OP_SUB:  OpSelect = ULA_SUB;
               OP_NAND: OpSelect = ULA_NAND;
               default: OpSelect = ULA_PASS;
            endcase
         end
         T3: begin
            Gout   = 1'b1;
            Rin    = w_x;
            Done   = 1'b1;
            w_next = T0;
         end
`ifdef UC_ILLEGAL_TRAP_EN
         TRAP: begin
            // Sticky until reset: only Erro is driven, OpSelect included in the blanking.
            Erro     = 1'b1;
            OpSelect = 3'b000;
         end
`endif
         default: w_next = T0;
      endcase

      // Reset blanks every output, not just the state-dependent ones.
      if (!Resetn) begin
         IRin     = 1'b0;
         Rin      = '0;
         Rout     = '0;
         Ain      = 1'b0;
         Gin      = 1'b0;
         Gout     = 1'b0;
         DINout   = 1'b0;
         OpSelect = 3'b000;
         Done     = 1'b0;
`ifdef UC_ILLEGAL_TRAP_EN
         Erro     = 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench: cycle-by-cycle vector table plus hand sequences for reset, NREG<8 and undefined opcodes.
module tb_unidade_controle;
   import uc_pkg::*;

   localparam logic [2:0] P = 3'b111;

   logic       Clock = 1'b0;
   logic       Resetn, Run;
   logic [8:0] DIN;
   logic       IRin, Ain, Gin, Gout, DINout, Done;
   logic [7:0] Rin, Rout;
   logic [2:0] OpSelect;
   logic       IRin4, Ain4, Gin4, Gout4, DINout4, Done4;
   logic [3:0] Rin4, Rout4;
   logic [2:0] OpSelect4;
`ifdef UC_ILLEGAL_TRAP_EN
   logic       Erro, Erro4;
`endif

   unidade_controle #(.NREG(8), .IW(9)) dut (
      .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
      .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin), .Gout(Gout),
      .DINout(DINout), .OpSelect(OpSelect), .Done(Done)
`ifdef UC_ILLEGAL_TRAP_EN
      , .Erro(Erro)
`endif
   );

   unidade_controle #(.NREG(4), .IW(9)) dut4 (
      .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
      .IRin(IRin4), .Rin(Rin4), .Rout(Rout4), .Ain(Ain4), .Gin(Gin4), .Gout(Gout4),
      .DINout(DINout4), .OpSelect(OpSelect4), .Done(Done4)
`ifdef UC_ILLEGAL_TRAP_EN
      , .Erro(Erro4)
`endif
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic        run;
      logic [8:0]  din;
      logic [24:0] exp;
   } rec_t;

   rec_t vec [23];
   int   n_chk = 0;
   int   n_err = 0;

   function automatic logic [24:0] mk(logic irin, logic [7:0] rin, logic [7:0] rout, logic ain,
                                      logic gin, logic gout, logic dinout, logic [2:0] op,
                                      logic done);
      return {irin, rin, rout, ain, gin, gout, dinout, op, done};
   endfunction

   function automatic logic [16:0] mk4(logic irin, logic [3:0] rin, logic [3:0] rout, logic ain,
                                       logic gin, logic gout, logic dinout, logic [2:0] op,
                                       logic done);
      return {irin, rin, rout, ain, gin, gout, dinout, op, done};
   endfunction

   task automatic chk(input string name, input logic [24:0] exp);
      logic [24:0] act;
      act = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, OpSelect, Done};
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h (IRin,Rin,Rout,Ain,Gin,Gout,DINout,Op,Done)",
                  name, act, exp);
      end
   endtask

   task automatic chk4(input string name, input logic [16:0] exp);
      logic [16:0] act;
      act = {IRin4, Rin4, Rout4, Ain4, Gin4, Gout4, DINout4, OpSelect4, Done4};
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

`ifdef UC_ILLEGAL_TRAP_EN
   task automatic chk_erro(input string name, input logic exp);
      n_chk++;
      if (Erro !== exp) begin
         n_err++;
         $display("FAIL %s Erro got=%b want=%b", name, Erro, exp);
      end
   endtask
`endif

   initial begin
      vec[0]  = '{1'b1, 9'b001_010_000, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, P, 0)};
      vec[1]  = '{1'b0, 9'h055,         mk(0, 8'h04, 8'h00, 0, 0, 0, 1, P, 1)};
      vec[2]  = '{1'b1, 9'b000_011_101, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, P, 0)};
      vec[3]  = '{1'b0, 9'h000,         mk(0, 8'h08, 8'h20, 0, 0, 0, 0, P, 1)};
      vec[4]  = '{1'b0, 9'h000,         mk(0, 8'h00, 8'h00, 0, 0, 0, 0, P, 0)};
      vec[5]  = '{1'b1, 9'b011_001_010, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, P, 0)};
      vec[6]  = '{1'b0, 9'h000,         mk(0, 8'h00, 8'h02, 1, 0, 0, 0, P, 0)};
      vec[7]  = '{1'b1, 9'h1FF,         mk(0, 8'h00, 8'h04, 0, 1, 0, 0, 3'b001, 0)};
      vec[8]  = '{1'b1, 9'h1FF,         mk(0, 8'h02, 8'h00, 0, 0, 1, 0, P, 1)};
      vec[9]  = '{1'b1, 9'b010_011_100, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, P, 0)};
      vec[10] = '{1'b1, 9'b100_101_110, mk(0, 8'h00, 8'h08, 1, 0, 0, 0, P, 0)};
      vec[11] = '{1'b1, 9'b100_101_110, mk(0, 8'h00, 8'h10, 0, 1, 0, 0, 3'b000, 0)};
      vec[12] = '{1'b1, 9'b100_101_110, mk(0, 8'h08, 8'h00, 0, 0, 1, 0, P, 1)};
      vec[13] = '{1'b1, 9'b100_101_110, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, P, 0)};
      vec[14] = '{1'b0, 9'h000,         mk(0, 8'h00, 8'h20, 1, 0, 0, 0, P, 0)};
      vec[15] = '{1'b0, 9'h000,         mk(0, 8'h00, 8'h40, 0, 1, 0, 0, 3'b010, 0)};
      vec[16] = '{1'b0, 9'h000,         mk(0, 8'h20, 8'h00, 0, 0, 1, 0, P, 1)};
      vec[17] = '{1'b0, 9'h000,         mk(0, 8'h00, 8'h00, 0, 0, 0, 0, P, 0)};
      vec[18] = '{1'b1, 9'b010_001_001, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, P, 0)};
      vec[19] = '{1'b0, 9'h000,         mk(0, 8'h00, 8'h02, 1, 0, 0, 0, P, 0)};
      vec[20] = '{1'b0, 9'h000,         mk(0, 8'h00, 8'h02, 0, 1, 0, 0, 3'b000, 0)};
      vec[21] = '{1'b0, 9'h000,         mk(0, 8'h02, 8'h00, 0, 0, 1, 0, P, 1)};
      vec[22] = '{1'b0, 9'h000,         mk(0, 8'h00, 8'h00, 0, 0, 0, 0, P, 0)};

      // Reset with Run high: everything, IRin and OpSelect included, must be zero.
      Resetn = 1'b0; Run = 1'b1; DIN = 9'b001_010_000;
      #2 chk("reset_outputs", '0);
`ifdef UC_ILLEGAL_TRAP_EN
      chk_erro("reset_erro", 1'b0);
`endif
      @(negedge Clock);
      Resetn = 1'b1;

      for (int i = 0; i < 23; i++) begin
         Run = vec[i].run; DIN = vec[i].din;
         #1 chk($sformatf("vec%0d", i), vec[i].exp);
         @(negedge Clock);
      end

      // Asynchronous reset in T2 of add R2,R3.
      Run = 1'b1; DIN = 9'b010_010_011;
      #1 chk("abort_t0", mk(1, 8'h00, 8'h00, 0, 0, 0, 0, P, 0));
      @(negedge Clock); Run = 1'b0;
      #1 chk("abort_t1", mk(0, 8'h00, 8'h04, 1, 0, 0, 0, P, 0));
      @(negedge Clock);
      #1 chk("abort_t2", mk(0, 8'h00, 8'h08, 0, 1, 0, 0, 3'b000, 0));
      #1 Resetn = 1'b0;
      #1 chk("abort_async_zero", '0);
      @(negedge Clock); Resetn = 1'b1;
      #1 chk("abort_idle0", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, P, 0));
      n_chk++;
      if (dut.r_state !== T0 || dut.r_ir !== 9'h000) begin
         n_err++;
         $display("FAIL abort_state got state=%0d ir=%h want state=0 ir=000", dut.r_state, dut.r_ir);
      end
      @(negedge Clock);
      #1 chk("abort_idle1", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, P, 0));
      @(negedge Clock);

      // Out-of-range indices on the NREG=4 instance.
      Run = 1'b1; DIN = 9'b000_101_010;
      #1 chk4("n4_mv52_t0", mk4(1, 4'h0, 4'h0, 0, 0, 0, 0, P, 0));
      @(negedge Clock); Run = 1'b0;
      #1 chk4("n4_mv52_t1", mk4(0, 4'h0, 4'h4, 0, 0, 0, 0, P, 1));
      chk("n8_mv52_t1", mk(0, 8'h20, 8'h04, 0, 0, 0, 0, P, 1));
      @(negedge Clock); Run = 1'b1; DIN = 9'b000_010_110;
      #1 chk4("n4_mv26_t0", mk4(1, 4'h0, 4'h0, 0, 0, 0, 0, P, 0));
      @(negedge Clock); Run = 1'b0;
      #1 chk4("n4_mv26_t1", mk4(0, 4'h4, 4'h0, 0, 0, 0, 0, P, 1));
      @(negedge Clock);

      // Undefined opcode 110_000_000.
      Run = 1'b1; DIN = 9'b110_000_000;
      #1 chk("undef_t0", mk(1, 8'h00, 8'h00, 0, 0, 0, 0, P, 0));
      @(negedge Clock); Run = 1'b0;
`ifdef UC_ILLEGAL_TRAP_EN
      #1 chk("undef_t1", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, P, 0));
      chk_erro("undef_t1_erro", 1'b0);
      @(negedge Clock);
      for (int k = 0; k < 10; k++) begin
         Run = 1'b1; DIN = 9'b001_001_000;
         #1 chk($sformatf("trap_hi%0d", k), '0);
         chk_erro($sformatf("trap_hi_erro%0d", k), 1'b1);
         @(negedge Clock); Run = 1'b0;
         #1 chk_erro($sformatf("trap_lo_erro%0d", k), 1'b1);
         @(negedge Clock);
      end
      Resetn = 1'b0;
      #1 chk_erro("trap_reset", 1'b0);
      @(negedge Clock); Resetn = 1'b1;
      #1 chk("trap_exit_idle", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, P, 0));
      chk_erro("trap_exit_erro", 1'b0);
`else
      #1 chk("undef_t1_nop", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, P, 1));
      @(negedge Clock);
      #1 chk("undef_back_t0", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, P, 0));
`endif
      @(negedge Clock);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
